lower_level_arbiter: RTL

//   Shares one lower-level cache/memory port between NUM_REQ upper-level requesters (e.g. I-L1 and D-L1 misses).

---
 rtl/lower_level_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/lower_level_arbiter.sv
// lower_level_arbiter: round-robin share of one lower-level cache/memory port among NUM_REQ requesters
module lower_level_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_LENGTH    = 10,
  parameter int BLOCK_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_enable,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_LENGTH-1:0] req_addr,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_fetchReceive,
  output logic [BLOCK_SIZE-1:0]          req_data_out,
  output logic                           low_enable,
  output logic                           low_write,
  output logic [ADDR_LENGTH-1:0]         low_addr,
  output logic [BLOCK_SIZE-1:0]          low_data_out,
  input  logic [BLOCK_SIZE-1:0]          low_data_in,
  input  logic                           low_fetchComplete,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REL} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, grant_q, grant_d, pick;
  logic [IW:0] idx;
  logic found, done, expire;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] recv_q, recv_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic en_q, en_d, wr_q, wr_d, tout_q, tout_d;
  // search starts one past the last grant so a lingering requester yields to the others
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_q} + (IW+1)'(k);
      idx = idx >= NR ? idx - NR : idx;
      if (!found && req_enable[idx[IW-1:0]]) begin
        found = 1'b1;
        pick = idx[IW-1:0];
      end
    end
  end
  assign done   = state_q == S_WAIT && low_fetchComplete;
  assign expire = state_q == S_WAIT && !low_fetchComplete && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == S_IDLE ? (found ? S_WAIT : S_IDLE) :
              state_q == S_WAIT ? (done || expire ? S_REL : S_WAIT) : S_IDLE;
  end
  always_comb begin
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (state_q == S_IDLE && found) begin
      last_d  = pick;
      grant_d = pick;
      addr_d  = req_addr[pick*ADDR_LENGTH +: ADDR_LENGTH];
      wr_d    = req_write[pick];
      wdata_d = req_data[pick*BLOCK_SIZE +: BLOCK_SIZE];
    end
    en_d = state_d == S_WAIT;
    cnt_d = state_q == S_WAIT ? cnt_q + CW'(1) : '0;
    recv_d = '0;
    if (done) recv_d[grant_q] = 1'b1;
    rdata_d = done && !wr_q ? low_data_in : rdata_q;
    tout_d = tout_q | expire;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      recv_q  <= '0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      recv_q  <= recv_d;
      rdata_q <= rdata_d;
      tout_q  <= tout_d;
    end
  end
  assign req_fetchReceive = recv_q;
  assign req_data_out     = rdata_q;
  assign low_enable       = en_q;
  assign low_write        = wr_q;
  assign low_addr         = addr_q;
  assign low_data_out     = wdata_q;
  assign busy             = state_q != S_IDLE;
  assign grant_id         = grant_q;
  assign timeout_err      = tout_q;
endmodule
